// File: rtl/nios_qsys_light_thresh.sv
// Light-sensor threshold classifier with hysteresis and debounce; emits an active-low
// event pulse toward the PIO in_port on every debounced DARK/BRIGHT change.
module nios_qsys_light_thresh #(
  parameter int DATA_W       = 12,
  parameter int PULSE_CYCLES = 4,
  parameter int HI_RST       = 3000,
  parameter int LO_RST       = 1000,
  parameter int DEB_RST      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              light_int_n,
  output logic              light_state
);

  localparam int PW = (PULSE_CYCLES > 2) ? $clog2(PULSE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DARK,
    S_PEND_B,
    S_BRIGHT,
    S_PEND_D
  } state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_LOW,
    P_GAP
  } pulse_t;

  state_t            state, state_nxt;
  pulse_t            p_state;
  logic [15:0]       cnt, cnt_nxt;
  logic [15:0]       deb, deb_eff;
  logic [DATA_W-1:0] hi, lo, last;
  logic              en, ovf, pending;
  logic [PW-1:0]     pcnt;
  logic              wr, en_off_wr, ovf_clr, ovf_set, evt;
  logic              brighter, darker;
  logic [31:0]       rd_mux;
  logic              unused_wd;

  assign wr        = chipselect & ~write_n;
  assign en_off_wr = wr && (address == 2'd3) && !writedata[0];
  assign ovf_clr   = wr && (address == 2'd3) && writedata[31];
  assign deb_eff   = (deb == 16'd0) ? 16'd1 : deb;
  assign brighter  = sample_data > hi;
  assign darker    = sample_data < lo;
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi   <= DATA_W'(HI_RST);
      lo   <= DATA_W'(LO_RST);
      deb  <= 16'(DEB_RST);
      en   <= 1'b0;
      last <= '0;
    end else begin
      if (sample_valid) last <= sample_data;
      if (wr) begin
        case (address)
          2'd1: hi <= writedata[DATA_W-1:0];
          2'd2: lo <= writedata[DATA_W-1:0];
          2'd3: begin
            en  <= writedata[0];
            deb <= writedata[23:8];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0: rd_mux[DATA_W-1:0] = last;
      2'd1: rd_mux[DATA_W-1:0] = hi;
      2'd2: rd_mux[DATA_W-1:0] = lo;
      default: begin
        rd_mux[0]    = en;
        rd_mux[1]    = light_state;
        rd_mux[2]    = ovf;
        rd_mux[23:8] = deb;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Disabling wins over any sample in the same cycle, so no event can escape it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    evt       = 1'b0;
    if (en_off_wr || !en) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else if (sample_valid) begin
      case (state)
        S_IDLE: begin
          state_nxt = brighter ? S_BRIGHT : S_DARK;
          cnt_nxt   = '0;
        end
        S_DARK: begin
          if (brighter) begin
            if (deb_eff == 16'd1) begin
              state_nxt = S_BRIGHT;
              cnt_nxt   = '0;
              evt       = 1'b1;
            end else begin
              state_nxt = S_PEND_B;
              cnt_nxt   = 16'd1;
            end
          end
        end
        S_PEND_B: begin
          if (!brighter) begin
            state_nxt = S_DARK;
            cnt_nxt   = '0;
          end else if (cnt + 16'd1 == deb_eff) begin
            state_nxt = S_BRIGHT;
            cnt_nxt   = '0;
            evt       = 1'b1;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        S_BRIGHT: begin
          if (darker) begin
            if (deb_eff == 16'd1) begin
              state_nxt = S_DARK;
              cnt_nxt   = '0;
              evt       = 1'b1;
            end else begin
              state_nxt = S_PEND_D;
              cnt_nxt   = 16'd1;
            end
          end
        end
        S_PEND_D: begin
          if (!darker) begin
            state_nxt = S_BRIGHT;
            cnt_nxt   = '0;
          end else if (cnt + 16'd1 == deb_eff) begin
            state_nxt = S_DARK;
            cnt_nxt   = '0;
            evt       = 1'b1;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    light_state = (state == S_BRIGHT) || (state == S_PEND_D);
  end

  // A pulse owns the line for its low time plus one high cycle; one extra event may queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_state     <= P_IDLE;
      pcnt        <= '0;
      light_int_n <= 1'b1;
      pending     <= 1'b0;
    end else begin
      case (p_state)
        P_IDLE: begin
          if (evt) begin
            p_state     <= P_LOW;
            pcnt        <= PW'(PULSE_CYCLES - 1);
            light_int_n <= 1'b0;
          end
        end
        P_LOW: begin
          if (pcnt == '0) begin
            p_state     <= P_GAP;
            light_int_n <= 1'b1;
          end else begin
            pcnt <= pcnt - PW'(1);
          end
          pending <= (pending | evt) & ~en_off_wr;
        end
        P_GAP: begin
          if ((pending && !en_off_wr) || evt) begin
            p_state     <= P_LOW;
            pcnt        <= PW'(PULSE_CYCLES - 1);
            light_int_n <= 1'b0;
          end else begin
            p_state <= P_IDLE;
          end
          pending <= 1'b0;
        end
        default: begin
          p_state     <= P_IDLE;
          light_int_n <= 1'b1;
          pending     <= 1'b0;
        end
      endcase
    end
  end

  assign ovf_set = evt && pending && (p_state != P_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_nios_qsys_light_thresh.sv
// Table-driven bench for nios_qsys_light_thresh: each row is one clock of stimulus
// with hand-computed outputs expected just after that clock edge.
module tb_nios_qsys_light_thresh;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        light_int_n;
  logic        light_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        sv;
    logic [11:0] sdata;
    logic        exp_int_n;
    logic        exp_state;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  nios_qsys_light_thresh #(
    .DATA_W(12), .PULSE_CYCLES(4), .HI_RST(3000), .LO_RST(1000), .DEB_RST(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sample_data(sample_data), .sample_valid(sample_valid),
    .address(address), .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .light_int_n(light_int_n), .light_state(light_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] a, input logic w, input logic [31:0] wd,
                         input logic sv, input logic [11:0] sd, input logic in_n,
                         input logic st, input logic chk, input logic [31:0] rd);
    vec_t v;
    v.addr = a; v.wr = w; v.wdata = wd; v.sv = sv; v.sdata = sd;
    v.exp_int_n = in_n; v.exp_state = st; v.chk_rd = chk; v.exp_rd = rd;
    tbl.push_back(v);
  endtask

  task automatic add_idle(input int n, input logic in_n, input logic st);
    for (int k = 0; k < n; k++) add_vec(2'd0, 1'b0, 0, 1'b0, 12'd0, in_n, st, 1'b0, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    address      = v.addr;
    chipselect   = v.wr;
    write_n      = ~v.wr;
    writedata    = v.wdata;
    sample_valid = v.sv;
    sample_data  = v.sdata;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    check_val({tag, " light_int_n"}, 32'(light_int_n), 32'(v.exp_int_n));
    check_val({tag, " light_state"}, 32'(light_state), 32'(v.exp_state));
    if (v.chk_rd) check_val({tag, " readdata"}, readdata, v.exp_rd);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput(v, tag);
  endtask

  initial begin
    vec_t v;
    reset_n = 1'b0;
    v = '{addr: 2'd0, wr: 1'b0, wdata: 0, sv: 1'b0, sdata: 12'd0,
          exp_int_n: 1'b1, exp_state: 1'b0, chk_rd: 1'b1, exp_rd: 0};
    applyStimulus(v);
    repeat (3) @(posedge clk);
    #1;
    checkOutput(v, "por");
    reset_n = 1'b1;

    // Debounced DARK -> BRIGHT with deb=3
    add_vec(2'd3, 1, 32'h301, 0, 0,    1, 0, 1, 32'h800);
    add_vec(2'd3, 0, 0,       1, 500,  1, 0, 1, 32'h301);
    add_vec(2'd0, 0, 0,       1, 3500, 1, 0, 1, 500);
    add_vec(2'd0, 0, 0,       1, 3500, 1, 0, 1, 3500);
    add_vec(2'd0, 0, 0,       1, 3500, 0, 1, 1, 3500);
    add_vec(2'd3, 0, 0,       0, 0,    0, 1, 1, 32'h303);
    add_idle(2, 0, 1);
    add_idle(2, 1, 1);
    // Glitch in the middle of a BRIGHT -> DARK debounce
    add_vec(2'd0, 0, 0, 1, 900,  1, 1, 0, 0);
    add_vec(2'd0, 0, 0, 1, 900,  1, 1, 0, 0);
    add_vec(2'd0, 0, 0, 1, 2000, 1, 1, 0, 0);
    add_vec(2'd0, 0, 0, 1, 900,  1, 1, 0, 0);
    add_vec(2'd0, 0, 0, 1, 900,  1, 1, 0, 0);
    add_vec(2'd0, 0, 0, 1, 900,  0, 0, 0, 0);
    add_idle(3, 0, 0);
    add_vec(2'd0, 0, 0, 0, 0, 1, 0, 0, 0);
    add_vec(2'd0, 0, 0, 0, 0, 1, 0, 1, 900);
    // deb=1, narrow hysteresis: back-to-back events, pending pulse and overflow
    add_vec(2'd1, 1, 2000,    0, 0,    1, 0, 1, 3000);
    add_vec(2'd2, 1, 1900,    0, 0,    1, 0, 1, 1000);
    add_vec(2'd3, 1, 32'h101, 0, 0,    1, 0, 1, 32'h301);
    add_vec(2'd3, 0, 0,       1, 2500, 0, 1, 1, 32'h101);
    add_vec(2'd0, 0, 0,       1, 1800, 0, 0, 0, 0);
    add_vec(2'd0, 0, 0,       1, 2500, 0, 1, 0, 0);
    add_vec(2'd3, 0, 0,       0, 0,    0, 1, 1, 32'h107);
    add_idle(1, 1, 1);
    add_idle(4, 0, 1);
    add_idle(1, 1, 1);
    add_vec(2'd3, 1, 32'h8000_0001, 0, 0, 1, 1, 1, 32'h107);
    add_vec(2'd3, 0, 0,             0, 0, 1, 1, 1, 32'h003);
    // Register write coinciding with a sample uses the old threshold; deb=0 acts as 1
    add_vec(2'd0, 0, 0,   1, 1000, 0, 0, 0, 0);
    add_vec(2'd1, 1, 100, 1, 150,  0, 0, 1, 2000);
    add_vec(2'd1, 0, 0,   1, 150,  0, 1, 1, 100);
    add_idle(1, 0, 1);
    add_idle(1, 1, 1);
    add_idle(4, 0, 1);
    add_idle(2, 1, 1);
    // Disable while PEND_B, then re-enable from IDLE
    add_vec(2'd3, 1, 32'h301, 0, 0,  1, 1, 1, 32'h003);
    add_vec(2'd0, 0, 0,       1, 50, 1, 1, 0, 0);
    add_vec(2'd0, 0, 0,       1, 50, 1, 1, 0, 0);
    add_vec(2'd0, 0, 0,       1, 50, 0, 0, 0, 0);
    add_idle(3, 0, 0);
    add_idle(2, 1, 0);
    add_vec(2'd0, 0, 0,       1, 4000, 1, 0, 0, 0);
    add_vec(2'd0, 0, 0,       1, 4000, 1, 0, 0, 0);
    add_vec(2'd3, 1, 32'h300, 0, 0,    1, 0, 1, 32'h301);
    add_vec(2'd0, 0, 0,       1, 4000, 1, 0, 0, 0);
    add_vec(2'd3, 0, 0,       0, 0,    1, 0, 1, 32'h300);
    add_vec(2'd0, 0, 0,       0, 0,    1, 0, 1, 4000);
    add_vec(2'd3, 1, 32'h301, 0, 0,    1, 0, 0, 0);
    add_vec(2'd0, 0, 0,       1, 4000, 1, 1, 0, 0);
    add_idle(1, 1, 1);
    add_vec(2'd3, 0, 0,       0, 0,    1, 1, 1, 32'h303);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("row%0d", i));

    // Reset asserted in the middle of a low pulse
    v = '{addr: 2'd3, wr: 1'b1, wdata: 32'h101, sv: 1'b0, sdata: 12'd0,
          exp_int_n: 1'b1, exp_state: 1'b1, chk_rd: 1'b0, exp_rd: 0};
    run_vec(v, "rst_prep");
    v = '{addr: 2'd0, wr: 1'b0, wdata: 0, sv: 1'b1, sdata: 12'd100,
          exp_int_n: 1'b0, exp_state: 1'b0, chk_rd: 1'b0, exp_rd: 0};
    run_vec(v, "rst_pulse");
    v.sv = 1'b0;
    run_vec(v, "rst_pulse2");
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rst_async light_int_n", 32'(light_int_n), 32'd1);
    check_val("rst_async light_state", 32'(light_state), 32'd0);
    check_val("rst_async readdata", readdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    v = '{addr: 2'd1, wr: 1'b0, wdata: 0, sv: 1'b0, sdata: 12'd0,
          exp_int_n: 1'b1, exp_state: 1'b0, chk_rd: 1'b1, exp_rd: 3000};
    run_vec(v, "rst_hi");
    v.addr = 2'd2; v.exp_rd = 1000;
    run_vec(v, "rst_lo");
    v.addr = 2'd3; v.exp_rd = 32'h800;
    run_vec(v, "rst_ctrl");
    v.addr = 2'd0; v.exp_rd = 0;
    run_vec(v, "rst_last");
    run_vec(v, "rst_quiet");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
